spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0), 8-bit, MSB first; the far-end counterpart of the team's spi_master.
- Used on the peripheral/test-fixture side, e.g. a loopback target for master bring-up or an FPGA-to-FPGA link.
- SCK, SS_N and MOSI are asynchronous to clk. They are oversampled through 2-FF synchronizers, and all logic runs in the clk domain.
- Full-duplex: shifts out a preloaded TX byte while shifting in the RX byte. Continuous multi-byte bursts are supported while SS_N stays low.

Parameters:
- DATA_W, 8, shift width; only 8 is verified.
- IDLE_TX, 8'h00, byte shifted out when no TX byte is loaded.

Ports:
- clk  in  1  system clock; f_sck must be ≤ f_clk/8.
- rst  in  1  asynchronous, active-low reset.
- ss_n  in  1  chip select from master, active low, asynchronous.
- sck  in  1  serial clock from master, asynchronous.
- mosi  in  1  serial data from master, asynchronous.
- miso  out  1  serial data to master; driven 0 whenever ss_n (synchronized) is high.
- data_in  in  8  TX byte to load.
- load  in  1  one-cycle strobe; writes data_in into the TX buffer.
- tx_empty  out  1  high when the TX buffer holds no unsent byte.
- data_out  out  8  last complete RX byte.
- new_data  out  1  one-cycle pulse when data_out updates.
- busy  out  1  high while selected (synchronized ss_n low).

Behaviour:
- Reset (rst low, asynchronous) values: miso=0, data_out=0, new_data=0, busy=0, tx_empty=1, TX buffer=IDLE_TX, shift reg=0, bit counter=0, state=IDLE, synchronizers=idle levels (ss_n=1, sck=0, mosi=0).
- Synchronization and edge detection:
  - Each of ss_n, sck and mosi passes through a 2-FF synchronizer, followed by a 3rd delay register.
  - An edge is detected combinationally from the 2nd vs 3rd stage.
  - Actions are registered, so a pin change takes effect on the 3rd clk rising edge after it.
- FSM states:
  - IDLE: ss_n high, miso=0.
    - On ss_n falling: shift reg ← TX buffer (or IDLE_TX if tx_empty), tx_empty←1, counter←0, miso←shift[7], go to SHIFT.
  - SHIFT, on each sck rising:
    - shift ← {shift[6:0], mosi_sync}; counter increments, wrapping 7→0.
    - When the counter was 7: data_out ← {shift[6:0], mosi_sync}, new_data=1 for one cycle, go to RELOAD.
  - SHIFT, on each sck falling:
    - If not the last bit, miso ← shift[7] (the new MSB after the shift).
  - RELOAD (byte boundary, ss_n still low): wait for sck falling.
    - Then shift ← TX buffer (or IDLE_TX if tx_empty), tx_empty←1, miso←shift[7], go to SHIFT.
    - ss_n rising here goes to IDLE with no further action.
- ss_n rising in any state goes to IDLE next cycle.
  - Mid-byte deassertion aborts: no new_data, data_out unchanged, counter←0, partial RX discarded.
  - A TX byte already moved to the shift reg is lost; the buffer is not restored.
- TX buffer:
  - load writes data_in and clears tx_empty. load while not empty overwrites.
  - If load coincides with a buffer→shift transfer: the shift reg takes the old buffer value (or IDLE_TX), then the buffer takes data_in and tx_empty=0. Load wins for the buffer.
- busy = ss_n_sync low, registered.
- sck edges while ss_n is high are ignored.
- A simultaneous ss_n falling and sck rising within one sync sample is a master timing violation and is undefined.
- new_data never asserts on consecutive cycles.

Decomposition:
- Shared package: SPI mode constants (CPOL/CPHA = 0), DATA_W default, FSM state encoding (IDLE, SHIFT, RELOAD; 2 bits), and the synchronizer depth constant (2).
- One natural sub-module: spi_sync_edge. It is a 1-bit 2-FF synchronizer plus delay register with outputs level, rise and fall. It is instantiated three times, for ss_n, sck and mosi (mosi uses level only).

Test Plan:
- Reset mid-byte: rst low after 4 bits → all outputs at reset values immediately; the next full transfer of 8'h3C gives data_out=8'h3C.
- Single byte: load 8'hA5; master sends 8'h5A at f_clk/8 → master receives 8'hA5; data_out=8'h5A; new_data pulses exactly once, 3 clk cycles after the 8th sck rising pin edge; tx_empty=1 after ss_n falls.
- Burst, 3 bytes, ss_n held low: load 8'h11, then load 8'h22 during byte 1 and 8'h33 during byte 2 → miso stream 11,22,33; RX 01,02,03 each flagged by its own new_data pulse.
- Underrun: no load, master sends 8'hFF → miso bytes equal IDLE_TX=8'h00; data_out=8'hFF.
- Abort: ss_n rises after 5 bits of 8'hC3 → no new_data; data_out keeps its prior value; busy falls 3 cycles later; the next full byte 8'h96 is received correctly from bit 0.
- Load collision: load 8'h77 on the same cycle ss_n falling is acted on, with buffer=8'h44 → first byte out is 8'h44; tx_empty=0; the next byte out is 8'h77.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants and FSM encoding for the SPI mode-0 slave.
package spi_slave_pkg;

  // SPI mode 0: clock idles low, data sampled on the rising edge
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // Default shift width
  localparam int DATA_W_DEF = 8;

  // Flip-flops in each pin synchronizer, before the edge-detect delay register
  localparam int SYNC_STAGES = 2;

  // Slave FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// One-bit pin synchronizer with a trailing delay register for edge detection.
// The level is the last synchronizer stage; rise/fall compare it against the
// delay register, so any action registered on them lands on the 3rd clk edge
// after the pin changes.
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   dly_reg;

  // Synchronizer chain plus delay stage, reset to the pin's idle level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= {SYNC_STAGES{RST_VAL}};
      dly_reg  <= RST_VAL;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      dly_reg  <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~dly_reg;
  assign fall  = ~level & dly_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, full duplex with a one-deep TX buffer.
// All pins are oversampled in the clk domain; f_sck must stay <= f_clk/8.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] IDLE_TX = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              tx_empty,
  output logic [DATA_W-1:0] data_out,
  output logic              new_data,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic ss_level, ss_rise, ss_fall;
  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  // Only the mosi level is used; its edges have no meaning on their own
  logic unused_sync;
  assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .din(ss_n),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                miso_reg, miso_next;
  logic [DATA_W-1:0]   data_out_reg, data_out_next;
  logic                new_data_reg, new_data_next;
  logic [DATA_W-1:0]   tx_buf_reg, tx_buf_next;
  logic                tx_empty_reg, tx_empty_next;
  logic                busy_reg, busy_next;

  // Byte handed to the shifter at a transfer: buffered data, or filler on underrun
  logic [DATA_W-1:0]   tx_src;
  logic                take_tx;
  assign tx_src = tx_empty_reg ? IDLE_TX : tx_buf_reg;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      miso_reg     <= 1'b0;
      data_out_reg <= '0;
      new_data_reg <= 1'b0;
      tx_buf_reg   <= IDLE_TX;
      tx_empty_reg <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      miso_reg     <= miso_next;
      data_out_reg <= data_out_next;
      new_data_reg <= new_data_next;
      tx_buf_reg   <= tx_buf_next;
      tx_empty_reg <= tx_empty_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    cnt_next      = cnt_reg;
    miso_next     = miso_reg;
    data_out_next = data_out_reg;
    new_data_next = 1'b0;
    busy_next     = ~ss_level;
    take_tx       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        miso_next = 1'b0;
        cnt_next  = '0;
        if (ss_fall) begin
          shift_next = tx_src;
          take_tx    = 1'b1;
          miso_next  = tx_src[DATA_W-1];
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (ss_rise) begin
          // Deselect mid-byte: drop the partial byte, no completion pulse
          cnt_next   = '0;
          miso_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (sck_rise) begin
          shift_next = {shift_reg[DATA_W-2:0], mosi_level};
          cnt_next   = cnt_reg + 1'b1;
          if (cnt_reg == LAST_BIT) begin
            cnt_next      = '0;
            data_out_next = {shift_reg[DATA_W-2:0], mosi_level};
            new_data_next = 1'b1;
            state_next    = ST_RELOAD;
          end
        end else if (sck_fall) begin
          miso_next = shift_reg[DATA_W-1];
        end
      end

      ST_RELOAD: begin
        if (ss_rise) begin
          miso_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (sck_fall) begin
          shift_next = tx_src;
          take_tx    = 1'b1;
          miso_next  = tx_src[DATA_W-1];
          state_next = ST_SHIFT;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A load always wins the buffer, even on the cycle the old byte is taken
    tx_buf_next   = tx_buf_reg;
    tx_empty_next = tx_empty_reg;
    if (load) begin
      tx_buf_next   = data_in;
      tx_empty_next = 1'b0;
    end else if (take_tx) begin
      tx_empty_next = 1'b1;
    end
  end

  assign miso     = miso_reg;
  assign data_out = data_out_reg;
  assign new_data = new_data_reg;
  assign tx_empty = tx_empty_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-byte transfers plus
// hand-written burst, abort, load-collision and reset sequences.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss_n = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] data_in = 8'h00;
  logic       load = 1'b0;
  logic       tx_empty;
  logic [7:0] data_out;
  logic       new_data;
  logic       busy;

  spi_slave #(.DATA_W(8), .IDLE_TX(8'h00)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck), .mosi(mosi), .miso(miso),
    .data_in(data_in), .load(load), .tx_empty(tx_empty),
    .data_out(data_out), .new_data(new_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int nd_count = 0;
  int nd_cyc  = 0;
  int rise_cyc = 0;
  logic [7:0] m_rx;

  always @(posedge clk) cyc++;

  // Count completion pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (new_data) begin
      nd_count++;
      nd_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %-16s act=%0h exp=%0h ok", nm, act, exp);
    end else begin
      $display("FAIL %-16s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_byte(input logic [7:0] d);
    data_in = d;
    load    = 1'b1;
    tick(1);
    load    = 1'b0;
  endtask

  // Master side, sck half period = 4 clk; master samples miso just before each rise
  task automatic sck_bits(input logic [7:0] mo, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      mosi = mo[7-i];
      tick(4);
      m_rx = {m_rx[6:0], miso};
      sck  = 1'b1;
      rise_cyc = cyc;
      tick(4);
      sck  = 1'b0;
    end
  endtask

  typedef struct {
    logic       do_load;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];
  int   nd0;

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
    vecs[1] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{1'b1, 8'hC3, 8'h3C, 8'hC3, 8'h3C};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h01};

    // Reset state
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_empty", 32'(tx_empty), 32'd1);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_new_data", 32'(new_data), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    rst = 1'b1;
    tick(4);

    // Single-byte transfers from the table
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].do_load) load_byte(vecs[v].tx);
      nd0  = nd_count;
      m_rx = 8'h00;
      ss_n = 1'b0;
      tick(4);
      chk("tx_empty_sel", 32'(tx_empty), 32'd1);
      chk("busy_sel", 32'(busy), 32'd1);
      sck_bits(vecs[v].mo, 0, 7);
      chk("miso_byte", 32'(m_rx), 32'(vecs[v].exp_miso));
      chk("data_out", 32'(data_out), 32'(vecs[v].exp_rx));
      chk("nd_pulses", 32'(nd_count - nd0), 32'd1);
      chk("nd_latency", 32'(nd_cyc - rise_cyc), 32'd3);
      ss_n = 1'b1;
      tick(4);
      chk("miso_idle", 32'(miso), 32'd0);
    end

    // Burst of three bytes with ss_n held low, loads during each byte
    load_byte(8'h11);
    nd0  = nd_count;
    ss_n = 1'b0;
    m_rx = 8'h00;
    sck_bits(8'h01, 0, 3);
    load_byte(8'h22);
    sck_bits(8'h01, 4, 7);
    chk("burst_miso0", 32'(m_rx), 32'h11);
    chk("burst_rx0", 32'(data_out), 32'h01);
    sck_bits(8'h02, 0, 3);
    load_byte(8'h33);
    sck_bits(8'h02, 4, 7);
    chk("burst_miso1", 32'(m_rx), 32'h22);
    chk("burst_rx1", 32'(data_out), 32'h02);
    sck_bits(8'h03, 0, 7);
    chk("burst_miso2", 32'(m_rx), 32'h33);
    chk("burst_rx2", 32'(data_out), 32'h03);
    chk("burst_pulses", 32'(nd_count - nd0), 32'd3);
    tick(4);
    ss_n = 1'b1;
    tick(4);

    // Abort after 5 bits: nothing delivered, busy drops on the 3rd edge
    nd0  = nd_count;
    ss_n = 1'b0;
    sck_bits(8'hC3, 0, 4);
    ss_n = 1'b1;
    tick(2);
    chk("abort_busy_hold", 32'(busy), 32'd1);
    tick(1);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_pulses", 32'(nd_count - nd0), 32'd0);
    chk("abort_data_out", 32'(data_out), 32'h03);
    tick(4);
    ss_n = 1'b0;
    sck_bits(8'h96, 0, 7);
    chk("after_abort_rx", 32'(data_out), 32'h96);
    ss_n = 1'b1;
    tick(4);

    // Load coinciding with the ss_n-fall transfer
    load_byte(8'h44);
    ss_n = 1'b0;
    tick(2);
    data_in = 8'h77;
    load    = 1'b1;
    tick(1);
    load    = 1'b0;
    chk("coll_tx_empty", 32'(tx_empty), 32'd0);
    m_rx = 8'h00;
    sck_bits(8'h00, 0, 7);
    chk("coll_miso0", 32'(m_rx), 32'h44);
    sck_bits(8'h00, 0, 7);
    chk("coll_miso1", 32'(m_rx), 32'h77);
    ss_n = 1'b1;
    tick(4);

    // Asynchronous reset in the middle of a byte
    ss_n = 1'b0;
    sck_bits(8'hF0, 0, 1);
    load_byte(8'h5A);
    sck_bits(8'hF0, 2, 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tx_empty", 32'(tx_empty), 32'd1);
    chk("mid_rst_data_out", 32'(data_out), 32'h00);
    chk("mid_rst_miso", 32'(miso), 32'd0);
    chk("mid_rst_new_data", 32'(new_data), 32'd0);
    ss_n = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(4);
    ss_n = 1'b0;
    sck_bits(8'h3C, 0, 7);
    chk("post_rst_rx", 32'(data_out), 32'h3C);
    ss_n = 1'b1;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
